// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM controller: FSM state encoding, SRAM bus widths
// and the default byte address of SRAM halfword 0.
package sram_defs;

  localparam int unsigned SRAM_AW = 18;
  localparam int unsigned SRAM_DW = 16;
  localparam int unsigned PHASE_W = 4;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  typedef enum logic [2:0] {
    IDLE,
    WR_LO,
    WR_HI,
    RD_LO,
    RD_HI,
    DONE
  } sram_state_e;

endpackage

// File: rtl/sram_controller_if.sv
// Bus bundle between the memory stage, the SRAM controller and the external SRAM.
// master: memory stage plus SRAM device side; slave: the controller.
interface sram_controller_if;
  import sram_defs::*;

  // Memory-stage side
  logic               rd_en;
  logic               wr_en;
  logic [31:0]        address;
  logic [31:0]        write_data;
  logic [31:0]        read_data;
  logic               ready;
  logic               addr_err;

  // External SRAM side
  logic [SRAM_AW-1:0] sram_addr;
  logic [SRAM_DW-1:0] sram_dq_out;
  logic [SRAM_DW-1:0] sram_dq_in;
  logic               sram_dq_oe;
  logic               sram_ce_n;
  logic               sram_oe_n;
  logic               sram_we_n;
  logic               sram_ub_n;
  logic               sram_lb_n;

  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_in,
    input  read_data, ready, addr_err, sram_addr, sram_dq_out, sram_dq_oe,
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );

  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_in,
    output read_data, ready, addr_err, sram_addr, sram_dq_out, sram_dq_oe,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );

endinterface

// File: rtl/sram_addr_map.sv
// Combinational address translation: byte address -> SRAM halfword-pair index,
// plus the range/alignment verdict used when range checking is built in.
module sram_addr_map
  import sram_defs::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic [31:0]        address,
  output logic [SRAM_AW-2:0] hw_index,
  output logic               addr_ok
);

  logic [31:0] offset;
  logic [1:0]  unused_offset_lsb;

  // Offset, word index and acceptance verdict.
  always_comb begin
    offset   = address - BASE_ADDR;
    hw_index = offset[18:2];
    addr_ok  = (address >= BASE_ADDR) && (offset[31:19] == 13'd0) && (address[1:0] == 2'b00);
  end

  // Byte lanes within a word are always accessed together.
  assign unused_offset_lsb = offset[1:0];

endmodule

// File: rtl/sram_controller.sv
// 32-bit load/store port onto a 16-bit asynchronous SRAM. Each word is moved as a
// low then high halfword phase of ACCESS_CYCLES cycles, followed by one DONE cycle
// in which ready rises. Optional feature: define SRAM_RANGE_CHECK_EN to reject
// out-of-range or misaligned requests with a one-cycle addr_err pulse.
module sram_controller
  import sram_defs::*;
#(
  parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  sram_controller_if.slave bus
);

  localparam logic [PHASE_W-1:0] LAST_CNT = PHASE_W'(ACCESS_CYCLES - 1);

  sram_state_e        state_q, state_d;
  logic [PHASE_W-1:0] cnt_q, cnt_d;
  logic [SRAM_DW-1:0] rd_lo_q;
  logic [31:0]        read_data_q;
  logic [SRAM_AW-2:0] hw_index;
  logic               addr_ok;
  logic               reject;
  logic               req;
  logic               last;

  sram_addr_map #(
    .BASE_ADDR(BASE_ADDR)
  ) u_addr_map (
    .address (bus.address),
    .hw_index(hw_index),
    .addr_ok (addr_ok)
  );

  assign req  = bus.rd_en | bus.wr_en;
  assign last = (cnt_q == LAST_CNT);

`ifdef SRAM_RANGE_CHECK_EN
  logic addr_err_q;

  assign reject = !addr_ok;

  // Registered so the pulse lands in the DONE cycle of the rejected request.
  always_ff @(posedge clk) begin
    if (rst) addr_err_q <= 1'b0;
    else     addr_err_q <= (state_q == IDLE) && req && reject;
  end

  assign bus.addr_err = addr_err_q;
`else
  logic unused_addr_ok;

  assign unused_addr_ok = addr_ok;
  assign reject         = 1'b0;
  assign bus.addr_err   = 1'b0;
`endif

  // State, phase counter and read capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_lo_q     <= '0;
      read_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == RD_LO && last) rd_lo_q <= bus.sram_dq_in;
      // The low half is staged so read_data only changes when a whole read completes.
      if (state_q == RD_HI && last) read_data_q <= {bus.sram_dq_in, rd_lo_q};
    end
  end

  // Next state: write wins over read; each phase lasts ACCESS_CYCLES cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req) begin
          if (reject)          state_d = DONE;
          else if (bus.wr_en)  state_d = WR_LO;
          else                 state_d = RD_LO;
        end
      end
      WR_LO, WR_HI, RD_LO, RD_HI: begin
        if (last) begin
          cnt_d = '0;
          unique case (state_q)
            WR_LO:   state_d = WR_HI;
            RD_LO:   state_d = RD_HI;
            default: state_d = DONE;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM strobes, address and write data decoded from the current state.
  always_comb begin
    bus.sram_ce_n   = 1'b1;
    bus.sram_oe_n   = 1'b1;
    bus.sram_we_n   = 1'b1;
    bus.sram_dq_oe  = 1'b0;
    bus.sram_addr   = '0;
    bus.sram_dq_out = '0;
    unique case (state_q)
      WR_LO: begin
        bus.sram_ce_n   = 1'b0;
        bus.sram_we_n   = 1'b0;
        bus.sram_dq_oe  = 1'b1;
        bus.sram_addr   = {hw_index, 1'b0};
        bus.sram_dq_out = bus.write_data[15:0];
      end
      WR_HI: begin
        bus.sram_ce_n   = 1'b0;
        bus.sram_we_n   = 1'b0;
        bus.sram_dq_oe  = 1'b1;
        bus.sram_addr   = {hw_index, 1'b1};
        bus.sram_dq_out = bus.write_data[31:16];
      end
      RD_LO: begin
        bus.sram_ce_n = 1'b0;
        bus.sram_oe_n = 1'b0;
        bus.sram_addr = {hw_index, 1'b0};
      end
      RD_HI: begin
        bus.sram_ce_n = 1'b0;
        bus.sram_oe_n = 1'b0;
        bus.sram_addr = {hw_index, 1'b1};
      end
      default: begin
      end
    endcase
  end

  // Pipeline handshake and fixed byte-lane enables.
  always_comb begin
    bus.ready     = !req || (state_q == DONE);
    bus.read_data = read_data_q;
    bus.sram_ub_n = 1'b0;
    bus.sram_lb_n = 1'b0;
  end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: stimulus pushes expected SRAM cycles and
// completions into queues; monitors on the falling edge pop and compare.
module tb_sram_controller;
  import sram_defs::*;

  localparam int unsigned AC  = 2;
  localparam int          LAT = 2 * AC + 1;

  typedef struct packed {
    logic [17:0] addr;
    logic        we_n;
    logic        oe_n;
    logic        dq_oe;
    logic        ub_n;
    logic        lb_n;
    logic [15:0] dq;
  } sram_rec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    int          done_cyc;
  } done_rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_rd;
  logic [15:0] mem [262144];
  logic [16:0] pv;

  sram_rec_t   exp_sram [$];
  done_rec_t   exp_done [$];
  sram_rec_t   sa, se;
  done_rec_t   de;

  sram_controller_if bus ();

  sram_controller #(
    .BASE_ADDR    (32'd1024),
    .ACCESS_CYCLES(AC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Locations the SRAM model returns without a prior write.
  function automatic logic [16:0] preset(input logic [17:0] a);
    case (a)
      18'd4:       return {1'b1, 16'h1234};
      18'd5:       return {1'b1, 16'hABCD};
      18'h3FFF4:   return {1'b1, 16'h1111};
      18'h3FFF5:   return {1'b1, 16'h2222};
      default:     return 17'h0;
    endcase
  endfunction

  // SRAM device model.
  always @(posedge clk) begin
    if (!bus.sram_ce_n && !bus.sram_we_n) mem[bus.sram_addr] <= bus.sram_dq_out;
  end

  always_comb begin
    pv = preset(bus.sram_addr);
    bus.sram_dq_in = 16'h0;
    if (!bus.sram_ce_n && !bus.sram_oe_n) bus.sram_dq_in = pv[16] ? pv[15:0] : mem[bus.sram_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every active SRAM cycle and every completed request.
  always @(negedge clk) begin
    if (!bus.sram_ce_n) begin
      sa = '{addr: bus.sram_addr, we_n: bus.sram_we_n, oe_n: bus.sram_oe_n,
             dq_oe: bus.sram_dq_oe, ub_n: bus.sram_ub_n, lb_n: bus.sram_lb_n,
             dq: bus.sram_dq_oe ? bus.sram_dq_out : 16'h0};
      if (exp_sram.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sram_stray: got addr=%0h we_n=%0b with nothing expected", sa.addr, sa.we_n);
      end else begin
        se = exp_sram.pop_front();
        check("sram_cycle", 64'(sa), 64'(se));
      end
    end
    if ((bus.rd_en || bus.wr_en) && bus.ready) begin
      if (exp_done.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_stray: got ready at cycle %0d with nothing expected", cyc);
      end else begin
        de = exp_done.pop_front();
        check("done_cycle", 64'(cyc), 64'(de.done_cyc));
        check("done_rdata", 64'(bus.read_data), 64'(de.rdata));
        check("done_err", 64'(bus.addr_err), 64'(de.err));
      end
    end else if (bus.addr_err) begin
      total++;
      bad++;
      $display("FAIL err_stray: got addr_err=1 at cycle %0d required 0", cyc);
    end
  end

  task automatic push_w(input logic [17:0] a, input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++)
      exp_sram.push_back('{addr: a, we_n: 1'b0, oe_n: 1'b1, dq_oe: 1'b1,
                           ub_n: 1'b0, lb_n: 1'b0, dq: d});
  endtask

  task automatic push_r(input logic [17:0] a, input int n);
    for (int i = 0; i < n; i++)
      exp_sram.push_back('{addr: a, we_n: 1'b1, oe_n: 1'b0, dq_oe: 1'b0,
                           ub_n: 1'b0, lb_n: 1'b0, dq: 16'h0});
  endtask

  // Called just after a rising edge; returns just after the edge ending DONE.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat,
                        input logic [31:0] exp_rdata, input logic exp_err, input bit hold);
    bit seen;
    exp_done.push_back('{rdata: exp_rdata, err: exp_err, done_cyc: cyc + lat});
    bus.rd_en      = rd;
    bus.wr_en      = wr;
    bus.address    = addr;
    bus.write_data = wdata;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.ready) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL timeout: got no ready for address %0d", addr);
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
    end
  endtask

  initial begin
    bus.rd_en      = 1'b0;
    bus.wr_en      = 1'b0;
    bus.address    = 32'd0;
    bus.write_data = 32'd0;
    rst            = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ce_n", 64'(bus.sram_ce_n), 64'd1);
    check("rst_oe_n", 64'(bus.sram_oe_n), 64'd1);
    check("rst_we_n", 64'(bus.sram_we_n), 64'd1);
    check("rst_dq_oe", 64'(bus.sram_dq_oe), 64'd0);
    check("rst_sram_addr", 64'(bus.sram_addr), 64'd0);
    check("rst_dq_out", 64'(bus.sram_dq_out), 64'd0);
    check("rst_read_data", 64'(bus.read_data), 64'd0);
    check("rst_addr_err", 64'(bus.addr_err), 64'd0);
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_ub_lb", 64'({bus.sram_ub_n, bus.sram_lb_n}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Write 0xDEADBEEF to byte 1024 -> halfwords 0/1.
    push_w(18'd0, 16'hBEEF, AC);
    push_w(18'd1, 16'hDEAD, AC);
    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, LAT, 32'h0, 1'b0, 1'b0);

    // Read byte 1032 -> halfwords 4/5.
    push_r(18'd4, AC);
    push_r(18'd5, AC);
    access(1'b1, 1'b0, 32'd1032, 32'h0, LAT, 32'hABCD1234, 1'b0, 1'b0);

    // Read and write together: write wins, read_data untouched.
    push_w(18'd2, 16'hF00D, AC);
    push_w(18'd3, 16'hCAFE, AC);
    access(1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, LAT, 32'hABCD1234, 1'b0, 1'b0);

    // Address below BASE_ADDR.
`ifdef SRAM_RANGE_CHECK_EN
    access(1'b1, 1'b0, 32'd1000, 32'h0, 1, 32'hABCD1234, 1'b1, 1'b0);
    last_rd = 32'hABCD1234;
`else
    push_r(18'h3FFF4, AC);
    push_r(18'h3FFF5, AC);
    access(1'b1, 1'b0, 32'd1000, 32'h0, LAT, 32'h22221111, 1'b0, 1'b0);
    last_rd = 32'h22221111;
`endif

    // Back-to-back write then read of byte 1036 -> halfwords 6/7, one IDLE between.
    push_w(18'd6, 16'hC0DE, AC);
    push_w(18'd7, 16'h0BAD, AC);
    push_r(18'd6, AC);
    push_r(18'd7, AC);
    access(1'b0, 1'b1, 32'd1036, 32'h0BADC0DE, LAT, last_rd, 1'b0, 1'b1);
    access(1'b1, 1'b0, 32'd1036, 32'h0, LAT, 32'h0BADC0DE, 1'b0, 1'b0);

    // Write request dropped after one cycle still runs to completion.
    push_w(18'd10, 16'h33CC, AC);
    push_w(18'd11, 16'h55AA, AC);
    bus.wr_en      = 1'b1;
    bus.address    = 32'd1044;
    bus.write_data = 32'h55AA33CC;
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
    repeat (2 * AC + 2) @(posedge clk);
    #1;

    // Reset during RD_HI of a read at byte 1040 -> halfwords 8/9.
    push_r(18'd8, AC);
    push_r(18'd9, 1);
    bus.rd_en   = 1'b1;
    bus.address = 32'd1040;
    repeat (AC + 1) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_ce_n", 64'(bus.sram_ce_n), 64'd1);
    check("abort_oe_n", 64'(bus.sram_oe_n), 64'd1);
    check("abort_read_data", 64'(bus.read_data), 64'd0);
    check("abort_ready", 64'(bus.ready), 64'd0);
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    rst       = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("sram_queue_left", 64'(exp_sram.size()), 64'd0);
    check("done_queue_left", 64'(exp_done.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
